// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified memory bus between the fetch-stage instruction port
// (I-side, read only) and the memory-stage data port (D-side, read/write).
// One transaction is outstanding at a time. D has fixed priority over I, but
// after MAX_D_STREAK consecutive D grants with if_req pending, I is forced.
//
// FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. Writes skip WAIT.
//
// Optional feature (macro ARB_PERF_EN): perf_i_wait / perf_d_wait count the
// cycles stall_f / stall_m are high (wrapping, cleared only by reset). When
// ARB_PERF_EN is undefined both outputs are tied to 0.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   if_req/if_addr           I-side read request, held until if_valid
//   if_rdata/if_valid        I-side read data (held) and completion pulse
//   dm_req/we/addr/wdata/be  D-side request, held until dm_valid
//   dm_rdata/dm_valid        D-side read data (held) and completion pulse
//   bus_req/we/addr/wdata/be bus transaction, bus_req held until bus_ack
//   bus_ack                  bus accepted the transaction
//   bus_rvalid/bus_rdata     read data return
//   stall_f/stall_m          per-side stall to the pipeline control
//   perf_i_wait/perf_d_wait  stall-cycle counters
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_valid,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_be,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_valid,
  output logic            bus_req,
  output logic            bus_we,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  output logic [DW/8-1:0] bus_be,
  input  logic            bus_ack,
  input  logic            bus_rvalid,
  input  logic [DW-1:0]   bus_rdata,
  output logic            stall_f,
  output logic            stall_m,
  output logic [31:0]     perf_i_wait,
  output logic [31:0]     perf_d_wait
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic          owner_d;   // 1: current transaction belongs to D-side
  logic [SW-1:0] streak;    // consecutive D grants while if_req pending
  logic          grant_d, grant_i;
  logic          streak_full;

  assign streak_full = (streak == SW'(MAX_D_STREAK));

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (dm_req && !(if_req && streak_full)) begin
          grant_d   = 1'b1;
          state_nxt = S_ISSUE;
        end else if (if_req) begin
          grant_i   = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: if (bus_ack)    state_nxt = bus_we ? S_DONE : S_WAIT;
      S_WAIT:  if (bus_rvalid) state_nxt = S_DONE;
      S_DONE:                  state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Transaction fields, owner and streak are latched only at grant, so the
  // losing side's inputs are never sampled and bus fields stay stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_d   <= 1'b0;
      streak    <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
    end else if (grant_d) begin
      owner_d   <= 1'b1;
      bus_we    <= dm_we;
      bus_addr  <= dm_addr;
      bus_wdata <= dm_wdata;
      bus_be    <= dm_be;
      // Only a D win over a waiting I counts towards the streak.
      if (!if_req)          streak <= '0;
      else if (!streak_full) streak <= streak + SW'(1);
    end else if (grant_i) begin
      owner_d   <= 1'b0;
      streak    <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= if_addr;
      bus_wdata <= '0;
      bus_be    <= '1;
    end
  end

  // Read data is steered to the owner only; the other side keeps its value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata <= '0;
      dm_rdata <= '0;
    end else if (state == S_WAIT && bus_rvalid) begin
      if (owner_d) dm_rdata <= bus_rdata;
      else         if_rdata <= bus_rdata;
    end
  end

  // Decoded from the state register so reset drops them asynchronously.
  assign bus_req  = (state == S_ISSUE);
  assign if_valid = (state == S_DONE) && !owner_d;
  assign dm_valid = (state == S_DONE) &&  owner_d;

  assign stall_f  = if_req && !if_valid;
  assign stall_m  = dm_req && !dm_valid;

`ifdef ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_i_wait <= '0;
      perf_d_wait <= '0;
    end else begin
      if (stall_f) perf_i_wait <= perf_i_wait + 32'd1;
      if (stall_m) perf_d_wait <= perf_d_wait + 32'd1;
    end
  end
`else
  assign perf_i_wait = '0;
  assign perf_d_wait = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives both request ports, models the memory bus (ack / rvalid with
// configurable or random delays, backing store), and checks completions via
// per-side scoreboard queues popped by an independent monitor.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXS = 4;
`ifdef ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [BW-1:0] dm_be;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [BW-1:0] bus_be;
  logic          bus_ack;
  logic          bus_rvalid;
  logic [DW-1:0] bus_rdata;
  logic          stall_f;
  logic          stall_m;
  logic [31:0]   perf_i_wait;
  logic [31:0]   perf_d_wait;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .stall_f(stall_f), .stall_m(stall_m),
    .perf_i_wait(perf_i_wait), .perf_d_wait(perf_d_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference data ----------------
  logic [31:0] bus_mem [bit [31:0]];   // bus-side backing store
  logic [31:0] d_ref   [bit [31:0]];   // D-side reference view
  logic [31:0] i_exp_q [$];
  logic [31:0] d_exp_q [$];
  logic [31:0] d_last;                 // last D read value (dm_rdata hold)
  bit          grant_log [$];          // 1 = D transaction, 0 = I

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return d_ref.exists(a) ? d_ref[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // ---------------- bus model ----------------
  int          ack_delay   = 0;
  int          rv_delay    = 0;
  bit          rand_delays = 1'b0;
  bit          override_en = 1'b0;
  logic [31:0] override_val = '0;
  int          late_rv_req  = 0;
  int          late_rv_done = 0;
  int          bm_phase, bm_cnt, bm_ad, bm_rd;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  task automatic bm_ack();
    bus_ack = 1'b1;
    if (cap_we) bus_mem[cap_addr] = merge(bus_rd(cap_addr), cap_wdata, cap_be);
    bm_phase = 2;
  endtask

  task automatic bm_rv();
    bus_rvalid = 1'b1;
    bus_rdata  = override_en ? override_val : bus_rd(cap_addr);
    bm_phase   = 3;
  endtask

  initial begin
    bus_ack = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    bm_phase = 0; bm_cnt = 0; bm_ad = 0; bm_rd = 0;
    cap_we = 1'b0; cap_addr = '0; cap_wdata = '0; cap_be = '0;
    forever begin
      @(negedge clk or negedge rst);
      if (!rst) begin
        bus_ack = 1'b0; bus_rvalid = 1'b0; bm_phase = 0;
        continue;
      end
      bus_ack = 1'b0; bus_rvalid = 1'b0;
      if (late_rv_req != late_rv_done) begin
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hBAD0_BAD0;
        late_rv_done++;
      end
      case (bm_phase)
        0: if (bus_req) begin
          cap_we = bus_we; cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be;
          grant_log.push_back(bus_addr < 32'h2000);
          if (bus_addr >= 32'h2000) begin
            check("i_bus_ctl", 32'({bus_we, bus_be}), 32'h0000_000F);
            check("i_bus_wdata", bus_wdata, 32'h0);
          end
          bm_ad  = rand_delays ? int'($urandom_range(0, 3)) : ack_delay;
          bm_rd  = rand_delays ? int'($urandom_range(0, 3)) : rv_delay;
          bm_cnt = 0;
          if (bm_ad == 0) bm_ack();
          else            bm_phase = 1;
        end
        1: begin
          check("bus_addr_stable", bus_addr, cap_addr);
          check("bus_wdata_stable", bus_wdata, cap_wdata);
          check("bus_ctl_stable", 32'({bus_req, bus_we, bus_be}), 32'({1'b1, cap_we, cap_be}));
          bm_cnt++;
          if (bm_cnt == bm_ad) bm_ack();
        end
        2: begin
          check("bus_req_drop", 32'(bus_req), 32'd0);
          if (cap_we) begin
            check("wr_valid_after_ack", 32'(dm_valid), 32'd1);
            bm_phase = 0;
          end else if (bm_rd == 0) begin
            bm_rv();
          end else begin
            bm_cnt   = 0;
            bm_phase = 4;
          end
        end
        4: begin
          bm_cnt++;
          if (bm_cnt == bm_rd) bm_rv();
        end
        3: bm_phase = 0;
        default: bm_phase = 0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] i_hold, d_hold;

  initial begin
    i_hold = '0; d_hold = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        i_hold = '0; d_hold = '0;
      end else begin
        if (if_valid) begin
          check("i_valid_excl", 32'(dm_valid), 32'd0);
          check("stall_f_on_valid", 32'(stall_f), 32'd0);
          if (i_exp_q.size() == 0) check("i_unexpected_valid", 32'(if_valid), 32'd0);
          else begin
            i_hold = i_exp_q.pop_front();
            check("if_rdata", if_rdata, i_hold);
            check("i_cpl_dm_rdata_held", dm_rdata, d_hold);
          end
        end
        if (dm_valid) begin
          check("stall_m_on_valid", 32'(stall_m), 32'd0);
          if (d_exp_q.size() == 0) check("d_unexpected_valid", 32'(dm_valid), 32'd0);
          else begin
            d_hold = d_exp_q.pop_front();
            check("dm_rdata", dm_rdata, d_hold);
            check("d_cpl_if_rdata_held", if_rdata, i_hold);
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic i_txn(input logic [31:0] addr, input logic [31:0] exp);
    int n = 0;
    if_req  = 1'b1;
    if_addr = addr;
    i_exp_q.push_back(exp);
    do begin @(negedge clk); n++; end while (!if_valid && n < 200);
    if (!if_valid) check("i_txn_timeout", 32'(if_valid), 32'd1);
  endtask

  task automatic d_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    int n = 0;
    logic [31:0] exp;
    if (we) begin
      d_ref[addr] = merge(ref_rd(addr), wdata, be);
      exp = d_last;
    end else begin
      exp    = ref_rd(addr);
      d_last = exp;
    end
    dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_be = be;
    d_exp_q.push_back(exp);
    do begin @(negedge clk); n++; end while (!dm_valid && n < 200);
    if (!dm_valid) check("d_txn_timeout", 32'(dm_valid), 32'd1);
  endtask

  task automatic i_seq(input int n, input int gap_max);
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      int gap = int'($urandom_range(0, gap_max));
      if (gap > 0) begin if_req = 1'b0; repeat (gap) @(negedge clk); end
      a = 32'h2000 + ($urandom_range(0, 255) << 2);
      i_txn(a, init_word(a));
    end
    if_req = 1'b0;
  endtask

  task automatic d_seq(input int n, input int gap_max);
    for (int k = 0; k < n; k++) begin
      int gap = int'($urandom_range(0, gap_max));
      if (gap > 0) begin dm_req = 1'b0; repeat (gap) @(negedge clk); end
      d_txn(bit'($urandom_range(0, 1)), 32'($urandom_range(0, 63) << 2),
            32'($urandom), 4'($urandom_range(0, 15)));
    end
    dm_req = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int  s_streak, ri, rdn;
    bit  exp_order [$];
    logic [31:0] a;

    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    d_last = '0;
    #1;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_valids", 32'({if_valid, dm_valid, bus_we}), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata_be", bus_wdata | 32'(bus_be), 32'd0);
    check("rst_rdata", if_rdata | dm_rdata, 32'd0);
    check("rst_perf", perf_i_wait | perf_d_wait, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Lone I read with exact latency.
    override_en = 1'b1; override_val = 32'hDEAD_BEEF; ack_delay = 0; rv_delay = 0;
    if_req = 1'b1; if_addr = 32'h100; i_exp_q.push_back(32'hDEAD_BEEF);
    #1;
    check("s1_c0_stall_f", 32'(stall_f), 32'd1);
    @(negedge clk);
    check("s1_c1_bus_req", 32'(bus_req), 32'd1);
    check("s1_c1_bus_addr", bus_addr, 32'h100);
    check("s1_c1_stall_f", 32'(stall_f), 32'd1);
    @(negedge clk);
    check("s1_c2_bus_req", 32'(bus_req), 32'd0);
    check("s1_c2_stall_f", 32'({stall_f, if_valid}), 32'd2);
    @(negedge clk);
    check("s1_c3_if_valid", 32'(if_valid), 32'd1);
    check("s1_c3_if_rdata", if_rdata, 32'hDEAD_BEEF);
    if_req = 1'b0;
    @(negedge clk);
    check("s1_c4_if_valid", 32'(if_valid), 32'd0);
    check("s1_i_fields", 32'({cap_we, cap_be}) | cap_wdata, 32'h0000_000F);
    check("s1_perf_i", perf_i_wait, PERF ? 32'd3 : 32'd0);
    check("s1_perf_d", perf_d_wait, 32'd0);
    override_en = 1'b0;

    // D write with ack delayed by 3 cycles.
    ack_delay = 3;
    fork
      d_txn(1'b1, 32'h40, 32'h1234_5678, 4'b0011);
      begin
        @(negedge clk);
        check("s2_stall_m", 32'({stall_m, bus_req}), 32'd3);
      end
    join
    dm_req = 1'b0;
    @(negedge clk);
    check("s2_cap_addr", cap_addr, 32'h40);
    check("s2_cap_wdata", cap_wdata, 32'h1234_5678);
    check("s2_cap_ctl", 32'({cap_we, cap_be}), 32'h0000_0013);
    check("s2_perf_d", perf_d_wait, PERF ? 32'd5 : 32'd0);

    // Simultaneous requests: D read first, then I.
    ack_delay = 0; rv_delay = 1;
    grant_log.delete();
    fork
      begin d_txn(1'b0, 32'h40, 32'h0, 4'h0); dm_req = 1'b0; end
      begin i_txn(32'h2040, init_word(32'h2040)); if_req = 1'b0; end
    join
    @(negedge clk);
    check("s3_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) check("s3_order", 32'({grant_log[0], grant_log[1]}), 32'd2);

    // Both held continuously: anti-starvation ordering.
    rv_delay = 0;
    grant_log.delete();
    fork
      i_seq(2, 0);
      d_seq(8, 0);
    join
    @(negedge clk);
    s_streak = 0; ri = 2; rdn = 8;
    while (ri + rdn > 0) begin
      if (rdn > 0 && !(ri > 0 && s_streak == MAXS)) begin
        exp_order.push_back(1'b1); rdn--;
        s_streak = (ri > 0) ? ((s_streak < MAXS) ? s_streak + 1 : s_streak) : 0;
      end else begin
        exp_order.push_back(1'b0); ri--; s_streak = 0;
      end
    end
    check("s4_grants", 32'(grant_log.size()), 32'(exp_order.size()));
    for (int k = 0; k < exp_order.size() && k < grant_log.size(); k++)
      check($sformatf("s4_order[%0d]", k), 32'(grant_log[k]), 32'(exp_order[k]));

    // Random traffic with random bus delays.
    rand_delays = 1'b1;
    fork
      i_seq(20, 3);
      d_seq(30, 3);
    join
    rand_delays = 1'b0;
    repeat (2) @(negedge clk);
    check("rand_queues_empty", 32'(i_exp_q.size() + d_exp_q.size()), 32'd0);

    // Reset while waiting for read data.
    ack_delay = 0; rv_delay = 6;
    if_req = 1'b1; if_addr = 32'h2100;
    repeat (3) @(negedge clk);
    check("s5_pre_bus_req", 32'(bus_req), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("s5_rst_bus_req", 32'(bus_req), 32'd0);
    check("s5_rst_valids", 32'({if_valid, dm_valid, bus_we}), 32'd0);
    check("s5_rst_bus_addr", bus_addr, 32'd0);
    check("s5_rst_bus_wdata_be", bus_wdata | 32'(bus_be), 32'd0);
    check("s5_rst_rdata", if_rdata | dm_rdata, 32'd0);
    check("s5_rst_perf", perf_i_wait | perf_d_wait, 32'd0);
    if_req = 1'b0;
    i_exp_q.delete(); d_exp_q.delete(); d_last = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    late_rv_req++;
    repeat (3) begin
      @(negedge clk);
      check("s5_late_rv_ignored", 32'({if_valid, dm_valid}) | if_rdata | dm_rdata, 32'd0);
    end
    rv_delay = 0;
    a = 32'h2200;
    i_txn(a, init_word(a));
    if_req = 1'b0;
    @(negedge clk);
    d_txn(1'b0, 32'h40, 32'h0, 4'h0);
    dm_req = 1'b0;
    repeat (2) @(negedge clk);
    check("s5_queues_empty", 32'(i_exp_q.size() + d_exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
